// File: rtl/totient_seq_ctrl.sv
// totient_seq_ctrl: computes Euler's totient phi(n) by sweeping a = 1..n
// through an external combinational coprime checker, one candidate per clock.
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   start, n_in      command strobe and operand; accepted only while idle
//   busy             high while a sweep is in progress
//   done             one-cycle pulse; phi_out valid from that cycle
//   phi_out          phi(n) result, held until the next command completes
//   cp_a, cp_b       candidate a and latched n driven to the checker
//   cp_valid         high when cp_a/cp_b carry a live query
//   cp_is_coprime    checker result for the current cp_a/cp_b (same cycle)
module totient_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] phi_out,
  output logic [WIDTH-1:0] cp_a,
  output logic [WIDTH-1:0] cp_b,
  output logic             cp_valid,
  input  logic             cp_is_coprime
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cp_a_d, cp_b_d, phi_d;
  logic             busy_d, done_d, valid_d;
  logic [WIDTH-1:0] inc;

  assign inc = WIDTH'(cp_is_coprime);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      cp_a     <= '0;
      cp_b     <= '0;
      phi_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cp_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cp_a     <= cp_a_d;
      cp_b     <= cp_b_d;
      phi_out  <= phi_d;
      busy     <= busy_d;
      done     <= done_d;
      cp_valid <= valid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cp_a_d  = cp_a;
    cp_b_d  = cp_b;
    phi_d   = phi_out;
    busy_d  = busy;
    done_d  = 1'b0;
    valid_d = cp_valid;

    case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          if (n_in != '0) begin
            cp_b_d  = n_in;
            cp_a_d  = WIDTH'(1);
            count_d = '0;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            state_d = SCAN;
          end else begin
            // n = 0: answer immediately, never query the checker with b = 0
            phi_d  = '0;
            done_d = 1'b1;
          end
        end
      end

      SCAN: begin
        if (cp_a != cp_b) begin
          count_d = count_q + inc;
          cp_a_d  = cp_a + WIDTH'(1);
        end else begin
          // Last candidate: a stops at n, so no wrap at n = 2^WIDTH-1
          phi_d   = count_q + inc;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_totient_seq_ctrl.sv
// tb_totient_seq_ctrl: directed bench for totient_seq_ctrl with a behavioural
// coprime checker and a scoreboard of expected phi(n) results.
module tb_totient_seq_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] n_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] phi_out;
  logic [WIDTH-1:0] cp_a;
  logic [WIDTH-1:0] cp_b;
  logic             cp_valid;
  logic             cp_is_coprime;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  totient_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .n_in         (n_in),
    .busy         (busy),
    .done         (done),
    .phi_out      (phi_out),
    .cp_a         (cp_a),
    .cp_b         (cp_b),
    .cp_valid     (cp_valid),
    .cp_is_coprime(cp_is_coprime)
  );

  function automatic int gcd(input int x, input int y);
    int a = x;
    int b = y;
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural coprime checker
  assign cp_is_coprime = (gcd(int'(cp_a), int'(cp_b)) == 1);

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pop_chk_phi(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, int'(phi_out), e);
    end
  endtask

  // Issue a command at a negedge and follow it to its done cycle.
  // noise: inject ignored start pulses (n_in=3) at sweep cycles 2 and 5.
  // abort_at: if nonzero, pulse rst_n at that sweep cycle and stop.
  // Returns at the negedge of the done cycle (or of the post-reset cycle).
  task automatic do_cmd(input int n, input int phi_exp, input bit noise,
                        input int abort_at);
    start = 1'b1;
    n_in  = WIDTH'(n);
    exp_q.push_back(phi_exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_in  = WIDTH'(n);
    if (n == 0) begin
      chk("n0_done", int'(done), 1);
      chk("n0_valid", int'(cp_valid), 0);
      chk("n0_busy", int'(busy), 0);
      pop_chk_phi("n0_phi");
      return;
    end
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("n%0d_cpa_%0d", n, k), int'(cp_a), k);
      chk($sformatf("n%0d_cpb_%0d", n, k), int'(cp_b), n);
      chk($sformatf("n%0d_valid_%0d", n, k), int'(cp_valid), 1);
      chk($sformatf("n%0d_busy_%0d", n, k), int'(busy), 1);
      chk($sformatf("n%0d_done_%0d", n, k), int'(done), 0);
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_phi", int'(phi_out), 0);
        chk("rst_valid", int'(cp_valid), 0);
        void'(exp_q.pop_back());
        return;
      end
      start = noise && (k == 2 || k == 5);
      n_in  = noise ? WIDTH'(3) : WIDTH'(n);
      @(negedge clk);
      start = 1'b0;
    end
    chk($sformatf("n%0d_done", n), int'(done), 1);
    chk($sformatf("n%0d_busy_end", n), int'(busy), 0);
    chk($sformatf("n%0d_valid_end", n), int'(cp_valid), 0);
    pop_chk_phi($sformatf("n%0d_phi", n));
  endtask

  task automatic idle_after(input string tag, input int phi_exp, input int a_exp);
    @(negedge clk);
    chk({tag, "_done_low"}, int'(done), 0);
    chk({tag, "_phi_hold"}, int'(phi_out), phi_exp);
    chk({tag, "_cpa_hold"}, int'(cp_a), a_exp);
    chk({tag, "_valid_low"}, int'(cp_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    n_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_phi", int'(phi_out), 0);
    chk("reset_valid", int'(cp_valid), 0);
    chk("reset_cpa", int'(cp_a), 0);
    chk("reset_cpb", int'(cp_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // phi(9) = 6
    do_cmd(9, 6, 1'b0, 0);
    idle_after("n9", 6, 9);

    // phi(1) = 1, then n = 0
    do_cmd(1, 1, 1'b0, 0);
    idle_after("n1", 1, 1);
    do_cmd(0, 0, 1'b0, 0);
    idle_after("n0", 0, 1);

    // Max operand, then back-to-back command issued in the done cycle
    do_cmd(15, 8, 1'b0, 0);
    do_cmd(12, 4, 1'b0, 0);
    idle_after("n12", 4, 12);

    // Start pulses during the sweep are ignored
    do_cmd(7, 6, 1'b1, 0);
    idle_after("n7", 6, 7);

    // Reset mid-sweep discards the partial result, then a fresh sweep
    do_cmd(10, 4, 1'b0, 4);
    chk("rst_cpa", int'(cp_a), 0);
    @(negedge clk);
    do_cmd(10, 4, 1'b0, 0);
    idle_after("n10", 4, 10);

    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
